// File: rtl/icon_pkg.sv
// Shared types and glyph tables for the RojoBot multi-bot sprite renderer.
package icon_pkg;

    localparam int ICON_CELLS_DEFAULT = 4;
    localparam int GLYPH_N            = 4;

    typedef enum logic [2:0] {
        HDG_N, HDG_NE, HDG_E, HDG_SE, HDG_S, HDG_SW, HDG_W, HDG_NW
    } heading_e;

    typedef enum logic [1:0] {
        ICON_CLR_NONE = 2'd0,
        ICON_CLR_BODY = 2'd1,
        ICON_CLR_HEAD = 2'd2,
        ICON_CLR_MARK = 2'd3
    } icon_clr_e;

    typedef struct packed {
        logic [7:0] info;
        logic [7:0] y;
        logic [7:0] x;
    } bot_state_t;

    // Master 4x4 glyphs, row-major (index = y*4 + x); other headings are rotations.
    localparam logic [1:0] GLYPH_ORTHO [16] = '{
        2'd3, 2'd2, 2'd2, 2'd3,
        2'd0, 2'd2, 2'd2, 2'd0,
        2'd1, 2'd1, 2'd1, 2'd1,
        2'd1, 2'd0, 2'd0, 2'd1
    };
    localparam logic [1:0] GLYPH_DIAG [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2,
        2'd1, 2'd1, 2'd2, 2'd2,
        2'd0, 2'd1, 2'd1, 2'd1,
        2'd3, 2'd0, 2'd1, 2'd0
    };

endpackage

// File: rtl/icon_sprite_engine_if.sv
// Pixel-in / icon-out bundle between the DTG, the sprite engine and the colourizer.
interface icon_sprite_engine_if #(
    parameter  int NUM_BOTS = 2,
    localparam int ID_W     = (NUM_BOTS > 1) ? $clog2(NUM_BOTS) : 1
);
    logic                    frame_start;
    logic                    pix_valid;
    logic [11:0]             pixel_column;
    logic [11:0]             pixel_row;
    logic [8*NUM_BOTS-1:0]   loc_x;
    logic [8*NUM_BOTS-1:0]   loc_y;
    logic [8*NUM_BOTS-1:0]   bot_info;
    logic [1:0]              icon;
    logic                    icon_valid;
    logic [ID_W-1:0]         icon_id;

    modport master (
        output frame_start, pix_valid, pixel_column, pixel_row, loc_x, loc_y, bot_info,
        input  icon, icon_valid, icon_id
    );
    modport slave (
        input  frame_start, pix_valid, pixel_column, pixel_row, loc_x, loc_y, bot_info,
        output icon, icon_valid, icon_id
    );
endinterface

// File: rtl/icon_bitmap_rom.sv
// Combinational heading-dependent icon bitmap: 8 headings x CELLS^2 x 2 bits.
// Even headings rotate the orthogonal glyph, odd headings rotate the diagonal one.
module icon_bitmap_rom
    import icon_pkg::*;
#(
    parameter  int CELLS = ICON_CELLS_DEFAULT,
    localparam int DW    = (CELLS > 1) ? $clog2(CELLS) : 1
) (
    input  logic [2:0]    heading,
    input  logic [DW-1:0] dx,
    input  logic [DW-1:0] dy,
    output logic [1:0]    pix
);

    logic [1:0] u, v, gx, gy;
    logic [3:0] idx;

    always_comb begin
        // Nearest-neighbour scale of the 4x4 master glyph onto the icon footprint.
        u  = 2'((int'(dx) * GLYPH_N) / CELLS);
        v  = 2'((int'(dy) * GLYPH_N) / CELLS);
        gx = u;
        gy = v;
        // Quarter turns clockwise: sample the master at the inverse-rotated point.
        case (heading[2:1])
            2'd0:    begin gx = u;         gy = v;         end
            2'd1:    begin gx = v;         gy = 2'd3 - u;  end
            2'd2:    begin gx = 2'd3 - u;  gy = 2'd3 - v;  end
            default: begin gx = 2'd3 - v;  gy = u;         end
        endcase
        idx = {gy, gx};
        pix = heading[0] ? GLYPH_DIAG[idx] : GLYPH_ORTHO[idx];
    end

endmodule

// File: rtl/icon_sprite_engine.sv
// Multi-bot sprite renderer: frame shadows, 2-stage pixel->cell->icon pipeline, priority mux.
// Optional blinking of alerted bots is built when ICON_BLINK_EN is defined.
module icon_sprite_engine
    import icon_pkg::*;
#(
    parameter  int NUM_BOTS   = 2,
    parameter  int ICON_CELLS = ICON_CELLS_DEFAULT,
    parameter  int CELL_W     = 8,
    parameter  int CELL_H     = 6,
    parameter  int BLINK_DIV  = 32,
    localparam int ID_W       = (NUM_BOTS > 1) ? $clog2(NUM_BOTS) : 1,
    localparam int DW         = (ICON_CELLS > 1) ? $clog2(ICON_CELLS) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    icon_sprite_engine_if.slave bus
);

    localparam int STAGES = 2;

    bot_state_t [NUM_BOTS-1:0]      shadow;
    logic [11:0]                    cell_x, cell_y;
    logic [STAGES:1]                vld_pipe;
    logic [1:0]                     icon_q, win_pix;
    logic [ID_W-1:0]                id_q, win_id;
    logic [NUM_BOTS-1:0]            hit, show;
    logic [NUM_BOTS-1:0][1:0]       bot_pix;
    logic                           blink_off;

    // Rendering only ever sees the bot state latched at the last frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
        end else if (bus.frame_start) begin
            for (int i = 0; i < NUM_BOTS; i++) begin
                shadow[i].x    <= bus.loc_x[8*i +: 8];
                shadow[i].y    <= bus.loc_y[8*i +: 8];
                shadow[i].info <= bus.bot_info[8*i +: 8];
            end
        end
    end

`ifdef ICON_BLINK_EN
    logic [7:0] frame_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)             frame_cnt <= '0;
        else if (bus.frame_start) frame_cnt <= frame_cnt + 8'd1;
    end

    assign blink_off = ((int'(frame_cnt) / BLINK_DIV) % 2) == 1;
`else
    logic unused_blink;
    assign unused_blink = (BLINK_DIV > 0);
    assign blink_off    = 1'b0;
`endif

    logic unused_info;
    always_comb begin
        unused_info = 1'b0;
        for (int i = 0; i < NUM_BOTS; i++) unused_info = unused_info ^ (^shadow[i].info[7:3]);
    end

    // Cell offsets are 13-bit signed so bots near 255 keep matching cells past 255.
    for (genvar b = 0; b < NUM_BOTS; b++) begin : g_bot
        logic signed [12:0] dx, dy;

        assign dx = $signed({1'b0, cell_x}) - $signed({5'b0, shadow[b].x});
        assign dy = $signed({1'b0, cell_y}) - $signed({5'b0, shadow[b].y});
        assign hit[b] = (dx >= 13'sd0) && (dx < $signed(13'(ICON_CELLS))) &&
                        (dy >= 13'sd0) && (dy < $signed(13'(ICON_CELLS)));

        icon_bitmap_rom #(.CELLS(ICON_CELLS)) u_rom (
            .heading (shadow[b].info[2:0]),
            .dx      (dx[DW-1:0]),
            .dy      (dy[DW-1:0]),
            .pix     (bot_pix[b])
        );

        assign show[b] = hit[b] && (bot_pix[b] != ICON_CLR_NONE) &&
                         !(blink_off && shadow[b].info[7]);
    end

    // Transparent glyph cells fall through to the next bot in index order.
    always_comb begin
        win_pix = ICON_CLR_NONE;
        win_id  = '0;
        for (int i = NUM_BOTS - 1; i >= 0; i--) begin
            if (show[i]) begin
                win_pix = bot_pix[i];
                win_id  = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            cell_x   <= '0;
            cell_y   <= '0;
            icon_q   <= '0;
            id_q     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], bus.pix_valid};
            cell_x   <= bus.pixel_column / 12'(CELL_W);
            cell_y   <= bus.pixel_row / 12'(CELL_H);
            icon_q   <= vld_pipe[1] ? win_pix : ICON_CLR_NONE;
            id_q     <= vld_pipe[1] ? win_id  : '0;
        end
    end

    assign bus.icon       = icon_q;
    assign bus.icon_id    = id_q;
    assign bus.icon_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_icon_sprite_engine.sv
// Scoreboard bench for icon_sprite_engine: directed cases plus randomized pixels and bots.
module tb_icon_sprite_engine;
    import icon_pkg::*;

    localparam int NB = 2;
    localparam int CW = 8;
    localparam int CH = 6;
    localparam int IC = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    icon_sprite_engine_if #(.NUM_BOTS(NB)) bus();

    icon_sprite_engine #(
        .NUM_BOTS(NB), .ICON_CELLS(IC), .CELL_W(CW), .CELL_H(CH), .BLINK_DIV(32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int icon;
        int id;
        int due;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   glyph [8][4][4];
    int   sh_x [NB];
    int   sh_y [NB];
    int   sh_h [NB];

    // Master glyphs [orthogonal, diagonal] as [y][x]; N and NE orientation.
    int base [2][4][4] = '{
        '{'{3,2,2,3}, '{0,2,2,0}, '{1,1,1,1}, '{1,0,0,1}},
        '{'{0,1,2,2}, '{1,1,2,2}, '{0,1,1,1}, '{3,0,1,0}}
    };

    always @(posedge clk) cyc <= cyc + 1;

    // Each pair of heading steps is the previous image turned 90 degrees clockwise.
    function automatic void build_glyphs();
        int cur [4][4];
        int tmp [4][4];
        for (int h = 0; h < 8; h++) begin
            cur = base[h % 2];
            for (int r = 0; r < h / 2; r++) begin
                for (int y = 0; y < 4; y++)
                    for (int x = 0; x < 4; x++)
                        tmp[x][3-y] = cur[y][x];
                cur = tmp;
            end
            glyph[h] = cur;
        end
    endfunction

    function automatic int model(input int col, input int row, output int id);
        int cx, cy, dx, dy;
        cx = col / CW;
        cy = row / CH;
        for (int b = 0; b < NB; b++) begin
            dx = cx - sh_x[b];
            dy = cy - sh_y[b];
            if (dx >= 0 && dx < IC && dy >= 0 && dy < IC && glyph[sh_h[b]][dy][dx] != 0) begin
                id = b;
                return glyph[sh_h[b]][dy][dx];
            end
        end
        id = 0;
        return 0;
    endfunction

    task automatic set_bot(input int b, input int x, input int y, input int h, input bit alert);
        bus.loc_x[8*b +: 8]    = 8'(x);
        bus.loc_y[8*b +: 8]    = 8'(y);
        bus.bot_info[8*b +: 8] = {alert, 4'b0, 3'(h)};
    endtask

    task automatic drive(input bit fs, input bit pv, input int col, input int row);
        exp_t e;
        int   id;
        bus.frame_start  = fs;
        bus.pix_valid    = pv;
        bus.pixel_column = 12'(col);
        bus.pixel_row    = 12'(row);
        if (fs && reset_n) begin
            for (int b = 0; b < NB; b++) begin
                sh_x[b] = int'(bus.loc_x[8*b +: 8]);
                sh_y[b] = int'(bus.loc_y[8*b +: 8]);
                sh_h[b] = int'(bus.bot_info[8*b +: 3]);
            end
        end
        if (pv && reset_n) begin
            e.icon = model(col, row, id);
            e.id   = id;
            e.due  = cyc + 2;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic enter_reset();
        reset_n = 1'b0;
        q.delete();
        for (int b = 0; b < NB; b++) begin
            sh_x[b] = 0;
            sh_y[b] = 0;
            sh_h[b] = 0;
        end
    endtask

    task automatic rand_step();
        int b, cx, cy, col, row;
        bit fs, pv;
        if ($urandom_range(0, 39) == 0) begin
            for (int k = 0; k < NB; k++)
                set_bot(k, $urandom_range(0, 255), $urandom_range(0, 255),
                        $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0)
                set_bot(1, int'(bus.loc_x[7:0]) + $urandom_range(0, 2),
                        int'(bus.loc_y[7:0]) + $urandom_range(0, 2), $urandom_range(0, 7), 1'b0);
        end
        if ($urandom_range(0, 9) < 7) begin
            b   = $urandom_range(0, NB - 1);
            cx  = int'(bus.loc_x[8*b +: 8]) + int'($urandom_range(0, 5)) - 1;
            cy  = int'(bus.loc_y[8*b +: 8]) + int'($urandom_range(0, 5)) - 1;
            col = cx * CW + int'($urandom_range(0, CW - 1));
            row = cy * CH + int'($urandom_range(0, CH - 1));
            if (col < 0) col = 0;
            if (row < 0) row = 0;
            if (col > 4095) col = 4095;
            if (row > 4095) row = 4095;
        end else begin
            col = $urandom_range(0, 4095);
            row = $urandom_range(0, 4095);
        end
        fs = ($urandom_range(0, 49) == 0);
        pv = ($urandom_range(0, 99) < 85);
        drive(fs, pv, col, row);
    endtask

    // Monitor: pops one expectation per valid output and checks idle outputs are zero.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.icon_valid) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_valid: got icon=%0d id=%0d, want no output", bus.icon, bus.icon_id);
                end else begin
                    e = q.pop_front();
                    if (int'(bus.icon) != e.icon || int'(bus.icon_id) != e.id || cyc != e.due) begin
                        miscompares++;
                        $display("FAIL pixel: got icon=%0d id=%0d cyc=%0d, want icon=%0d id=%0d cyc=%0d",
                                 bus.icon, bus.icon_id, cyc, e.icon, e.id, e.due);
                    end
                end
            end else begin
                vectors++;
                if (bus.icon !== 2'b00 || bus.icon_id !== '0) begin
                    miscompares++;
                    $display("FAIL idle_zero: got icon=%0d id=%0d, want 0 0", bus.icon, bus.icon_id);
                end
            end
        end
    end

    initial begin
        int waited;
        build_glyphs();
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b0;
        bus.pixel_column = '0;
        bus.pixel_row    = '0;
        for (int b = 0; b < NB; b++) set_bot(b, 0, 0, 0, 1'b0);
        enter_reset();

        // Reset held with live pixels: no output may appear.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, $urandom_range(0, 4095), $urandom_range(0, 4095));
        reset_n = 1'b1;
        drive(1'b0, 1'b1, 8, 6);
        drive(1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 0, 0);

        // Single bot at (10,20) heading N: inside then outside the footprint.
        set_bot(0, 10, 20, HDG_N, 1'b0);
        set_bot(1, 200, 200, HDG_N, 1'b0);
        drive(1'b1, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 80, 120);
        drive(1'b0, 1'b1, 112, 120);

        // Heading sweep; even headings share the cycle with frame_start.
        for (int h = 0; h < 8; h++) begin
            set_bot(0, 10, 20, h, 1'b0);
            if (h % 2 == 0) begin
                drive(1'b1, 1'b1, 88, 126);
            end else begin
                drive(1'b1, 1'b0, 0, 0);
                drive(1'b0, 1'b1, 88, 126);
            end
        end

        // Overlap: bot0 wins, then bot0 transparent cell lets bot1 through.
        set_bot(0, 30, 30, HDG_N, 1'b0);
        set_bot(1, 30, 30, HDG_S, 1'b0);
        drive(1'b1, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 240, 180);
        drive(1'b0, 1'b1, 240, 186);

        // Mid-frame location change is invisible until the next frame_start.
        set_bot(0, 12, 30, HDG_N, 1'b0);
        drive(1'b0, 1'b1, 240, 180);
        drive(1'b1, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 240, 180);

        // Right edge: footprint continues past cell 255.
        set_bot(0, 254, 5, HDG_E, 1'b0);
        drive(1'b1, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 2048, 36);
        drive(1'b0, 1'b1, 2047, 36);
        drive(1'b0, 1'b1, 2063, 42);
        drive(1'b0, 1'b1, 2064, 36);
        drive(1'b0, 1'b1, 0, 36);

        // Async reset mid-stream flushes in-flight pixels and shadows.
        drive(1'b0, 1'b1, 2048, 36);
        enter_reset();
        drive(1'b0, 1'b1, 2048, 36);
        drive(1'b0, 1'b1, 2048, 36);
        reset_n = 1'b1;
        drive(1'b0, 1'b1, 8, 6);
        drive(1'b0, 1'b1, 16, 12);

        for (int i = 0; i < 800; i++) rand_step();

        waited = 0;
        while (q.size() != 0 && waited < 10) begin
            drive(1'b0, 1'b0, 0, 0);
            waited++;
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d outputs still pending, want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
